// File: rtl/fila_cmd_if.sv
`default_nettype none
// ============================================================================
// Module      : fila_cmd_if
// Description : Button/switch inputs and queue-side strobes of the command stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface fila_cmd_if;
  logic       btn_enq_in;
  logic       btn_deq_in;
  logic [7:0] sw_data_in;
  logic       enqueue_out;
  logic       dequeue_out;
  logic [7:0] data_out;

  // master: board/stimulus side; slave: the command controller
  modport master (
    output btn_enq_in, btn_deq_in, sw_data_in,
    input  enqueue_out, dequeue_out, data_out
  );

  modport slave (
    input  btn_enq_in, btn_deq_in, sw_data_in,
    output enqueue_out, dequeue_out, data_out
  );
endinterface
`default_nettype wire

// File: rtl/fila_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fila_cmd_ctrl
// Description : Debounces enqueue/dequeue buttons into single-cycle queue
//               strobes with a captured data byte. Optional auto-repeat while
//               a button is held: define FILA_CMD_AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fila_cmd_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 200,
  parameter int unsigned REPEAT_CYCLES   = 5000
) (
  input  wire logic clk_10KHz,
  input  wire logic reset,
  fila_cmd_if.slave cmd
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam logic [15:0] c_db_term = 16'(DEBOUNCE_CYCLES);

  logic [1:0] w_raw;   // bit 0: enqueue, bit 1: dequeue
  logic [1:0] w_evt;

  assign w_raw = {cmd.btn_deq_in, cmd.btn_enq_in};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic        r_sync1;
    logic        r_sync2;
    db_state_t   r_state;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        w_press;

    assign w_cnt_nxt = r_cnt + 16'd1;
    assign w_press   = (r_state == PRESS_WAIT) && r_sync2 && (w_cnt_nxt == c_db_term);

    always_ff @(posedge clk_10KHz or negedge reset) begin
      if (!reset) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= w_raw[g];
        r_sync2 <= r_sync1;
      end
    end

    // Counter parks at the terminal value while HELD so it can never wrap
    always_ff @(posedge clk_10KHz or negedge reset) begin
      if (!reset) begin
        r_state <= IDLE;
        r_cnt   <= 16'd0;
      end else begin
        case (r_state)
          IDLE: begin
            if (r_sync2) begin
              r_state <= PRESS_WAIT;
              r_cnt   <= 16'd1;
            end
          end
          PRESS_WAIT: begin
            if (!r_sync2) begin
              r_state <= IDLE;
              r_cnt   <= 16'd0;
            end else if (w_cnt_nxt == c_db_term) begin
              r_state <= HELD;
              r_cnt   <= c_db_term;
            end else begin
              r_cnt   <= w_cnt_nxt;
            end
          end
          HELD: begin
            if (!r_sync2) begin
              r_state <= RELEASE_WAIT;
              r_cnt   <= 16'd1;
            end
          end
          RELEASE_WAIT: begin
            if (r_sync2) begin
              r_state <= HELD;
              r_cnt   <= c_db_term;
            end else if (w_cnt_nxt == c_db_term) begin
              r_state <= IDLE;
              r_cnt   <= 16'd0;
            end else begin
              r_cnt   <= w_cnt_nxt;
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= 16'd0;
          end
        endcase
      end
    end

`ifdef FILA_CMD_AUTO_REPEAT_EN
    localparam logic [15:0] c_rep_term = 16'(REPEAT_CYCLES);

    logic [15:0] r_rep;
    logic [15:0] w_rep_nxt;
    logic        w_rep_hit;

    assign w_rep_nxt = r_rep + 16'd1;
    assign w_rep_hit = (r_state == HELD) && r_sync2 && (w_rep_nxt == c_rep_term);

    always_ff @(posedge clk_10KHz or negedge reset) begin
      if (!reset) begin
        r_rep <= 16'd0;
      end else if ((r_state != HELD) || !r_sync2 || w_rep_hit) begin
        r_rep <= 16'd0;
      end else begin
        r_rep <= w_rep_nxt;
      end
    end

    assign w_evt[g] = w_press | w_rep_hit;
`else
    assign w_evt[g] = w_press;
`endif
  end

  logic       r_enq;
  logic       r_deq;
  logic       r_pend;
  logic [7:0] r_data;

  // Enqueue wins a tie; the losing dequeue waits one cycle in r_pend
  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      r_enq  <= 1'b0;
      r_deq  <= 1'b0;
      r_pend <= 1'b0;
      r_data <= 8'h00;
    end else begin
      r_enq <= w_evt[0];
      if (w_evt[0]) begin
        r_data <= cmd.sw_data_in;
        r_deq  <= 1'b0;
        r_pend <= r_pend | w_evt[1];
      end else begin
        r_deq  <= w_evt[1] | r_pend;
        r_pend <= w_evt[1] & r_pend;
      end
    end
  end

  assign cmd.enqueue_out = r_enq;
  assign cmd.dequeue_out = r_deq;
  assign cmd.data_out    = r_data;

endmodule
`default_nettype wire

// File: tb/tb_fila_cmd_ctrl.sv
`default_nettype none
// Bench for fila_cmd_ctrl: directed plan scenarios plus random button
// traffic compared each edge against a run-length reference model.
module tb_fila_cmd_ctrl;
  localparam int D = 4;
  localparam int R = 10;
`ifdef FILA_CMD_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk_10KHz = 1'b0;
  logic reset     = 1'b0;

  fila_cmd_if cmd ();

  fila_cmd_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk_10KHz(clk_10KHz),
    .reset    (reset),
    .cmd      (cmd)
  );

  always #50 clk_10KHz = ~clk_10KHz;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: raw input reaches the debouncer two edges late; a level
  // flips once the opposite value has been seen D edges in a row.
  bit [1:0]   m_dly0, m_dly1, m_lvl;
  int         m_run  [2];
  int         m_held [2];
  int         m_owed;
  bit         m_enq, m_deq;
  logic [7:0] m_data;

  int         edge_no, enq_cnt, deq_cnt, enq_first, deq_first;
  int         enq_edges [$];
  logic [7:0] enq_datas [$];

  int         rem_e, rem_d;
  bit         lv_e, lv_d;
  logic [7:0] rsw;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, edge_no);
  endtask

  task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_no);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_dly0 = '0; m_dly1 = '0; m_lvl = '0;
    m_run[0] = 0; m_run[1] = 0; m_held[0] = 0; m_held[1] = 0;
    m_owed = 0; m_enq = 1'b0; m_deq = 1'b0; m_data = 8'h00;
  endtask

  task automatic model_edge(input bit enq, input bit deq, input logic [7:0] sw);
    bit [1:0] v, ev;
    v = m_dly1; m_dly1 = m_dly0; m_dly0 = {deq, enq}; ev = 2'b00;
    for (int b = 0; b < 2; b++) begin
      if (v[b] == m_lvl[b]) begin
        m_run[b] = 0;
        if (m_lvl[b]) begin
          m_held[b]++;
          if (AR && m_held[b] == R) begin ev[b] = 1'b1; m_held[b] = 0; end
        end
      end else begin
        m_run[b]++;
        if (m_lvl[b]) m_held[b] = -1;
        if (m_run[b] == D) begin
          m_lvl[b] = v[b]; m_run[b] = 0;
          if (v[b]) begin ev[b] = 1'b1; m_held[b] = 0; end
        end
      end
    end
    m_owed += int'(ev[1]);
    m_enq = ev[0];
    if (ev[0]) m_data = sw;
    if (!ev[0] && m_owed > 0) begin m_deq = 1'b1; m_owed--; end
    else m_deq = 1'b0;
  endtask

  task automatic begin_test();
    edge_no = 0; enq_cnt = 0; deq_cnt = 0; enq_first = -1; deq_first = -1;
    enq_edges.delete(); enq_datas.delete();
  endtask

  task automatic step(input bit enq, input bit deq, input logic [7:0] sw);
    cmd.btn_enq_in = enq; cmd.btn_deq_in = deq; cmd.sw_data_in = sw;
    @(posedge clk_10KHz);
    model_edge(enq, deq, sw);
    edge_no++;
    #1;
    check_bit ("enqueue_out", cmd.enqueue_out, m_enq);
    check_bit ("dequeue_out", cmd.dequeue_out, m_deq);
    check_byte("data_out",    cmd.data_out,    m_data);
    check_bit ("exclusive",   cmd.enqueue_out & cmd.dequeue_out, 1'b0);
    if (cmd.enqueue_out === 1'b1) begin
      enq_cnt++;
      if (enq_first < 0) enq_first = edge_no;
      enq_edges.push_back(edge_no);
      enq_datas.push_back(cmd.data_out);
    end
    if (cmd.dequeue_out === 1'b1) begin
      deq_cnt++;
      if (deq_first < 0) deq_first = edge_no;
    end
    @(negedge clk_10KHz);
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b0;
    model_reset();
    repeat (cycles) begin
      @(posedge clk_10KHz);
      #1;
      check_bit ("rst_enqueue", cmd.enqueue_out, 1'b0);
      check_bit ("rst_dequeue", cmd.dequeue_out, 1'b0);
      check_byte("rst_data",    cmd.data_out,    8'h00);
      @(negedge clk_10KHz);
    end
    reset = 1'b1;
  endtask

  initial begin
    cmd.btn_enq_in = 1'b0; cmd.btn_deq_in = 1'b0; cmd.sw_data_in = 8'h00;
    model_reset();
    @(negedge clk_10KHz);
    apply_reset(3);

    // Idle after reset
    begin_test();
    repeat (20) step(1'b0, 1'b0, 8'h00);
    check_int ("idle_pulses", enq_cnt + deq_cnt, 0);
    check_byte("idle_data", cmd.data_out, 8'h00);

    // Single press, switches A5
    begin_test();
    repeat (30) step(1'b1, 1'b0, 8'hA5);
    repeat (15) step(1'b0, 1'b0, 8'hA5);
    check_int("press_first_edge", enq_first, 6);
    if (enq_datas.size() > 0) check_byte("press_data", enq_datas[0], 8'hA5);
    else check_int("press_data_present", 0, 1);
`ifndef FILA_CMD_AUTO_REPEAT_EN
    check_int("press_count", enq_cnt, 1);
`else
    check_int("press_count_rep", enq_cnt, 3);
`endif

    // Bouncing dequeue then steady high
    begin_test();
    step(1'b0, 1'b1, 8'h00); step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00); step(1'b0, 1'b0, 8'h00);
    repeat (12) step(1'b0, 1'b1, 8'h00);
    repeat (10) step(1'b0, 1'b0, 8'h00);
    check_int("bounce_deq_count", deq_cnt, 1);
    check_int("bounce_deq_edge",  deq_first, 10);
    check_int("bounce_enq_count", enq_cnt, 0);

    // Simultaneous press: enqueue first, dequeue one cycle later
    begin_test();
    repeat (12) step(1'b1, 1'b1, 8'h3C);
    repeat (10) step(1'b0, 1'b0, 8'h3C);
    check_int("both_enq_edge", enq_first, 6);
    check_int("both_deq_edge", deq_first, 7);
    check_int("both_enq_count", enq_cnt, 1);
    check_int("both_deq_count", deq_cnt, 1);

    // Reset mid-press with the button still held
    begin_test();
    repeat (3) step(1'b1, 1'b0, 8'h5A);
    apply_reset(2);
    check_int("midrst_no_pulse", enq_cnt, 0);
    begin_test();
    repeat (12) step(1'b1, 1'b0, 8'h5A);
    repeat (10) step(1'b0, 1'b0, 8'h5A);
    check_int("midrst_first_edge", enq_first, 6);
    check_int("midrst_count", enq_cnt, 1);

    // Long hold with switches changing mid-hold
    begin_test();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, (i < 10) ? 8'h01 : 8'h02);
    repeat (10) step(1'b0, 1'b0, 8'h02);
`ifdef FILA_CMD_AUTO_REPEAT_EN
    check_int("rep_count", enq_cnt, 4);
    if (enq_edges.size() == 4) begin
      check_int ("rep_edge0", enq_edges[0], 6);
      check_int ("rep_edge1", enq_edges[1], 16);
      check_int ("rep_edge2", enq_edges[2], 26);
      check_int ("rep_edge3", enq_edges[3], 36);
      check_byte("rep_data0", enq_datas[0], 8'h01);
      check_byte("rep_data1", enq_datas[1], 8'h02);
      check_byte("rep_data3", enq_datas[3], 8'h02);
    end
`else
    check_int("hold_count", enq_cnt, 1);
    if (enq_datas.size() > 0) check_byte("hold_data", enq_datas[0], 8'h01);
    else check_int("hold_data_present", 0, 1);
`endif

    // Random button traffic against the model
    begin_test();
    rem_e = 0; rem_d = 0; lv_e = 1'b0; lv_d = 1'b0; rsw = 8'h00;
    for (int i = 0; i < 800; i++) begin
      if (rem_e == 0) begin lv_e = 1'($urandom_range(0, 1)); rem_e = $urandom_range(1, 9); end
      if (rem_d == 0) begin lv_d = 1'($urandom_range(0, 1)); rem_d = $urandom_range(1, 9); end
      if ($urandom_range(0, 7) == 0) rsw = 8'($urandom);
      step(lv_e, lv_d, rsw);
      rem_e--; rem_d--;
    end
    repeat (12) step(1'b0, 1'b0, rsw);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
